// File: rtl/mgmt_spi_master_if.sv
// Request/response handshake and management SPI pins of mgmt_spi_master.
// The controller side uses modport master; the requester/SPI peer uses slave.
interface mgmt_spi_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       mgmt_clk;
  logic       mgmt_cs_n;
  logic       mgmt_mosi;
  logic       mgmt_miso;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, mgmt_miso,
    output req_ready, rsp_valid, rsp_rdata, busy, mgmt_clk, mgmt_cs_n, mgmt_mosi
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, mgmt_miso,
    input  req_ready, rsp_valid, rsp_rdata, busy, mgmt_clk, mgmt_cs_n, mgmt_mosi
  );
endinterface

// File: rtl/mgmt_spi_master.sv
// SPI mode-0 management master: one 24-bit frame (cmd, addr, data) per request.
// SPI pins are registered from the FSM state, so they trail the state by one clk.
module mgmt_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mgmt_spi_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      r_state, w_state_next;
  logic [7:0]  r_div_cnt, w_div_cnt_next;
  logic [4:0]  r_bit_cnt, w_bit_cnt_next;
  logic        r_phase_hi, w_phase_hi_next;
  logic [23:0] r_shift, w_shift_next;
  logic        r_write, w_write_next;
  logic [7:0]  r_rx;
  logic        r_miso_meta, r_miso_sync;
  logic        r_mgmt_clk, r_mgmt_cs_n, r_mgmt_mosi, r_rsp_valid;
  logic [7:0]  r_rsp_rdata;
  logic        w_clk_next, w_cs_n_next, w_mosi_next, w_rsp_valid_next;
  logic [7:0]  w_rsp_rdata_next;
  logic        w_div_last;
  logic        w_capture;

  assign w_div_last = (r_div_cnt == DIV_LAST);
  // Read data is sampled on the rising mgmt_clk edges of the last byte.
  assign w_capture  = w_clk_next && !r_mgmt_clk && (r_bit_cnt >= 5'd16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_div_cnt   <= 8'd0;
      r_bit_cnt   <= 5'd0;
      r_phase_hi  <= 1'b0;
      r_shift     <= 24'd0;
      r_write     <= 1'b0;
      r_rx        <= 8'd0;
      r_miso_meta <= 1'b0;
      r_miso_sync <= 1'b0;
      r_mgmt_clk  <= 1'b0;
      r_mgmt_cs_n <= 1'b1;
      r_mgmt_mosi <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_div_cnt   <= w_div_cnt_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_phase_hi  <= w_phase_hi_next;
      r_shift     <= w_shift_next;
      r_write     <= w_write_next;
      r_miso_meta <= bus.mgmt_miso;
      r_miso_sync <= r_miso_meta;
      if (w_capture) begin
        r_rx <= {r_rx[6:0], r_miso_sync};
      end
      r_mgmt_clk  <= w_clk_next;
      r_mgmt_cs_n <= w_cs_n_next;
      r_mgmt_mosi <= w_mosi_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_rdata <= w_rsp_rdata_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_div_cnt_next   = r_div_cnt;
    w_bit_cnt_next   = r_bit_cnt;
    w_phase_hi_next  = r_phase_hi;
    w_shift_next     = r_shift;
    w_write_next     = r_write;
    w_clk_next       = 1'b0;
    w_cs_n_next      = 1'b1;
    w_mosi_next      = 1'b0;
    w_rsp_valid_next = 1'b0;
    w_rsp_rdata_next = r_rsp_rdata;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_state_next   = SETUP;
          w_div_cnt_next = 8'd0;
          w_write_next   = bus.req_write;
          w_shift_next   = {(bus.req_write ? 8'h02 : 8'h03), bus.req_addr,
                            (bus.req_write ? bus.req_wdata : 8'h00)};
        end
      end
      SETUP: begin
        w_cs_n_next = 1'b0;
        w_mosi_next = r_shift[23];
        if (w_div_last) begin
          w_state_next    = SHIFT;
          w_div_cnt_next  = 8'd0;
          w_bit_cnt_next  = 5'd0;
          w_phase_hi_next = 1'b1;
        end else begin
          w_div_cnt_next = r_div_cnt + 8'd1;
        end
      end
      SHIFT: begin
        w_cs_n_next = 1'b0;
        w_clk_next  = r_phase_hi;
        w_mosi_next = r_shift[23];
        if (w_div_last) begin
          w_div_cnt_next = 8'd0;
          // Advancing the shifter at the end of the high phase moves MOSI with the falling edge.
          if (r_phase_hi) begin
            w_phase_hi_next = 1'b0;
            w_shift_next    = {r_shift[22:0], 1'b0};
          end else if (r_bit_cnt == 5'd23) begin
            w_state_next = DONE;
          end else begin
            w_bit_cnt_next  = r_bit_cnt + 5'd1;
            w_phase_hi_next = 1'b1;
          end
        end else begin
          w_div_cnt_next = r_div_cnt + 8'd1;
        end
      end
      DONE: begin
        w_rsp_valid_next = 1'b1;
        w_rsp_rdata_next = r_write ? 8'h00 : r_rx;
        w_state_next     = GAP;
        w_div_cnt_next   = 8'd0;
      end
      GAP: begin
        if (w_div_last) begin
          w_state_next = IDLE;
        end else begin
          w_div_cnt_next = r_div_cnt + 8'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.mgmt_clk  = r_mgmt_clk;
  assign bus.mgmt_cs_n = r_mgmt_cs_n;
  assign bus.mgmt_mosi = r_mgmt_mosi;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mgmt_spi_master.sv
// Bench for mgmt_spi_master: SPI slave model with a register file, a timeline
// model of the expected pin behaviour checked every cycle, and directed requests.
module tb_mgmt_spi_master;
  localparam int D     = 4;
  localparam int T_RSP = 49 * D + 1;
  localparam int T_END = 50 * D;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cycleNum = 0;

  mgmt_spi_master_if bus();

  mgmt_spi_master #(.CLK_DIV(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleNum <= cycleNum + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SPI slave: registers 0x00..0x0C writable, 0x0D status, anything else reads 0xFF.
  logic [7:0]  sRegs [0:15] = '{default: 8'h00};
  logic [23:0] sRx = 24'd0;
  logic [23:0] sLastFrame = 24'd0;
  logic [7:0]  sTx = 8'hFF;
  int          sCnt = 0;
  logic        sMiso = 1'b1;

  assign bus.mgmt_miso = sMiso;

  always @(posedge bus.mgmt_clk or posedge bus.mgmt_cs_n) begin
    if (bus.mgmt_cs_n) begin
      sCnt <= 0;
    end else begin
      sRx  <= {sRx[22:0], bus.mgmt_mosi};
      sCnt <= sCnt + 1;
      if (sCnt == 15) begin
        if ({sRx[6:0], bus.mgmt_mosi} <= 8'd12) sTx <= sRegs[{sRx[2:0], bus.mgmt_mosi}];
        else if ({sRx[6:0], bus.mgmt_mosi} == 8'd13) sTx <= 8'hC3;
        else sTx <= 8'hFF;
      end
      if (sCnt == 23) begin
        sLastFrame <= {sRx[22:0], bus.mgmt_mosi};
        if (sRx[22:15] == 8'h02 && sRx[14:7] <= 8'd12) sRegs[sRx[10:7]] <= {sRx[6:0], bus.mgmt_mosi};
      end
    end
  end

  always @(negedge bus.mgmt_clk or posedge bus.mgmt_cs_n) begin
    if (bus.mgmt_cs_n) sMiso <= 1'b1;
    else if (sCnt >= 16 && sCnt < 24) sMiso <= sTx[3'(23 - sCnt)];
  end

  // Expected behaviour as a timeline measured in clk edges from the accept edge.
  logic        mActive = 1'b0;
  int          mT = 0;
  logic [23:0] mFrame = 24'd0;
  logic        mWrite = 1'b0;
  logic [7:0]  mAddr = 8'd0;
  logic [7:0]  mHold = 8'd0;
  logic [7:0]  mRegs [0:15] = '{default: 8'h00};

  function automatic logic [7:0] expRead(input logic [7:0] a);
    if (a <= 8'd12) return mRegs[a[3:0]];
    else if (a == 8'd13) return 8'hC3;
    else return 8'hFF;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mActive <= 1'b0;
      mT      <= 0;
      mHold   <= 8'h00;
    end else if (mActive) begin
      if (mT == T_END) mActive <= 1'b0;
      else mT <= mT + 1;
      if (mT + 1 == T_RSP) begin
        mHold <= mWrite ? 8'h00 : expRead(mAddr);
        if (mWrite && mAddr <= 8'd12) mRegs[mAddr[3:0]] <= mFrame[7:0];
      end
    end else if (bus.req_valid) begin
      mActive <= 1'b1;
      mT      <= 0;
      mWrite  <= bus.req_write;
      mAddr   <= bus.req_addr;
      mFrame  <= {(bus.req_write ? 8'h02 : 8'h03), bus.req_addr,
                  (bus.req_write ? bus.req_wdata : 8'h00)};
    end
  end

  always @(negedge clk) begin
    logic expCs, expClk, expMosi, expRv, expBusy, expReady;
    int   u, idx;
    expCs = 1'b1; expClk = 1'b0; expMosi = 1'b0; expRv = 1'b0; expBusy = 1'b0; expReady = 1'b1;
    if (rst_n && mActive) begin
      expBusy  = 1'b1;
      expReady = 1'b0;
      u        = mT - (D + 1);
      expCs    = !(mT >= 1 && mT <= 49 * D);
      expClk   = (u >= 0 && u < 48 * D && ((u / D) % 2 == 0));
      if (mT >= 1 && mT <= D) begin
        expMosi = mFrame[23];
      end else if (u >= 0 && u < 48 * D) begin
        idx     = (u + D) / (2 * D);
        expMosi = (idx < 24) ? mFrame[23 - idx] : 1'b0;
      end
      expRv = (mT == T_RSP);
    end
    checkOutput("cs_n", bus.mgmt_cs_n, expCs);
    checkOutput("mgmt_clk", bus.mgmt_clk, expClk);
    checkOutput("mosi", bus.mgmt_mosi, expMosi);
    checkOutput("rsp_valid", bus.rsp_valid, expRv);
    checkOutput("rsp_rdata", bus.rsp_rdata, mHold);
    checkOutput("busy", bus.busy, expBusy);
    if (rst_n) checkOutput("req_ready", bus.req_ready, expReady);
  end

  // The wait helpers are entered at a negedge and return at a negedge.
  task automatic waitReady(output int acceptEdge);
    acceptEdge = -1;
    for (int i = 0; i < 400; i++) begin
      if (bus.req_ready) begin
        acceptEdge = cycleNum + 1;
        break;
      end
      @(negedge clk);
    end
    if (acceptEdge < 0) checkOutput("accept timeout", 0, 1);
  endtask

  task automatic waitRsp(output int rspEdge, output logic [7:0] rdata);
    rspEdge = -1;
    rdata   = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if (bus.rsp_valid) begin
        rspEdge = cycleNum;
        rdata   = bus.rsp_rdata;
        break;
      end
      @(negedge clk);
    end
    if (rspEdge < 0) checkOutput("rsp timeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                               output int latency, output logic [7:0] rdata);
    int a, r;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    waitReady(a);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = ~wr;
    bus.req_addr  = ~addr;
    bus.req_wdata = ~wdata;
    waitRsp(r, rdata);
    latency = r - a;
  endtask

  initial begin
    int         lat, a1, r1, a2, r2, rspCount;
    logic [7:0] rd;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;

    repeat (3) @(negedge clk);
    checkOutput("reset cs_n", bus.mgmt_cs_n, 1);
    checkOutput("reset mgmt_clk", bus.mgmt_clk, 0);
    checkOutput("reset mosi", bus.mgmt_mosi, 0);
    checkOutput("reset rsp_valid", bus.rsp_valid, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready after reset", bus.req_ready, 1);

    applyStimulus(1'b1, 8'h0C, 8'hA5, lat, rd);
    checkOutput("write latency", lat, 197);
    checkOutput("write rdata", rd, 8'h00);
    checkOutput("write frame", sLastFrame, 24'h020CA5);
    checkOutput("slave ctrl reg", sRegs[12], 8'hA5);

    applyStimulus(1'b1, 8'h05, 8'h3C, lat, rd);
    applyStimulus(1'b0, 8'h05, 8'h00, lat, rd);
    checkOutput("read 0x05 frame", sLastFrame, 24'h030500);
    checkOutput("read 0x05 data", rd, 8'h3C);
    checkOutput("read latency", lat, 197);

    applyStimulus(1'b0, 8'h20, 8'h00, lat, rd);
    checkOutput("read 0x20 data", rd, 8'hFF);
    applyStimulus(1'b0, 8'h0D, 8'h00, lat, rd);
    checkOutput("read status", rd, 8'hC3);
    applyStimulus(1'b0, 8'h0C, 8'h00, lat, rd);
    checkOutput("read ctrl", rd, 8'hA5);

    // Two requests with req_valid held high throughout.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h01;
    bus.req_wdata = 8'h11;
    waitReady(a1);
    @(negedge clk);
    bus.req_addr  = 8'h02;
    bus.req_wdata = 8'h22;
    waitRsp(r1, rd);
    waitReady(a2);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("b2b first latency", r1 - a1, 197);
    checkOutput("b2b accept gap", a2 - r1, 5);
    waitRsp(r2, rd);
    checkOutput("b2b second latency", r2 - a2, 197);
    applyStimulus(1'b0, 8'h01, 8'h00, lat, rd);
    checkOutput("b2b read 0x01", rd, 8'h11);
    applyStimulus(1'b0, 8'h02, 8'h00, lat, rd);
    checkOutput("b2b read 0x02", rd, 8'h22);

    // Reset pulse while bit 10 is on the wire.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h77;
    waitReady(a1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (78) @(negedge clk);
    checkOutput("bit 10 clk high", bus.mgmt_clk, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort cs_n", bus.mgmt_cs_n, 1);
    checkOutput("abort mgmt_clk", bus.mgmt_clk, 0);
    checkOutput("abort busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    rspCount = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) rspCount++;
    end
    checkOutput("no rsp after abort", rspCount, 0);
    checkOutput("aborted write dropped", sRegs[0], 8'h00);

    applyStimulus(1'b1, 8'h00, 8'h12, lat, rd);
    checkOutput("post-reset write latency", lat, 197);
    applyStimulus(1'b0, 8'h00, 8'h00, lat, rd);
    checkOutput("post-reset read 0x00", rd, 8'h12);

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mgmt_spi_master.md
MGMT_SPI_MASTER -- requirements
Module: mgmt_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per mgmt_clk half-period; legal range 3..255.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is rising-edge clk.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1, meaning a register request is offered.
REQ-005 SHALL have port req_ready, output, 1, meaning the block can accept a request.
REQ-006 SHALL have port req_write, input, 1, selecting write (1) or read (0).
REQ-007 SHALL have port req_addr, input, 8, the register address.
REQ-008 SHALL have port req_wdata, input, 8, the write data.
REQ-009 SHALL have port rsp_valid, output, 1, a one-cycle pulse marking completion.
REQ-010 SHALL have port rsp_rdata, output, 8, the read data, valid with rsp_valid.
REQ-011 SHALL have port busy, output, 1, asserted when not IDLE.
REQ-012 SHALL have ports mgmt_clk (output, 1), mgmt_cs_n (output, 1), mgmt_mosi (output, 1) and mgmt_miso (input, 1), forming the management SPI link.

Function
REQ-013 SHALL implement SPI mode 0 with mgmt_clk idle low: the slave samples MOSI on the rising edge and the master samples MISO on the rising edge, MSB first.
REQ-014 SHALL accept a request on a clk edge with req_valid && req_ready and capture req_write, req_addr and req_wdata; later input changes SHALL be ignored.
REQ-015 SHALL assert req_ready only in IDLE.
REQ-016 SHALL sequence the FSM IDLE -> SETUP -> SHIFT -> DONE -> GAP -> IDLE.
REQ-017 SETUP: from the cycle after accept, SHALL drive mgmt_cs_n=0, mgmt_clk=0 and mgmt_mosi=bit 7 of the first byte, for CLK_DIV cycles.
REQ-018 SHIFT: SHALL run 24 bits, each with mgmt_clk high for CLK_DIV cycles then low for CLK_DIV cycles; mgmt_mosi SHALL change only on the cycle mgmt_clk falls.
REQ-019 The frame SHALL be: byte 1 = 0x02 for a write or 0x03 for a read, byte 2 = addr, byte 3 = wdata for a write or 0x00 for a read.
REQ-020 SHALL pass mgmt_miso through a 2-flop synchronizer and capture the synchronized value on each cycle mgmt_clk rises during bits 17..24, shifting it in MSB first.
REQ-021 DONE (one cycle): SHALL drive mgmt_cs_n=1 with mgmt_clk=0 and pulse rsp_valid; rsp_rdata SHALL be the captured byte for a read and 0x00 for a write.
REQ-022 rsp_valid SHALL occur exactly 49*CLK_DIV+1 cycles after the accept edge (197 for CLK_DIV=4).
REQ-023 GAP: SHALL hold mgmt_cs_n=1 for CLK_DIV cycles before returning to IDLE, so the next accept is at least CLK_DIV+1 cycles after rsp_valid.
REQ-024 mgmt_cs_n SHALL never change while mgmt_clk=1, and mgmt_clk SHALL never pulse while mgmt_cs_n=1.
REQ-025 SHALL transmit addresses outside 0x00..0x0D unchanged and return whatever is sampled (0xFF from the slave).
REQ-026 rsp_rdata SHALL hold its value until the next rsp_valid.
REQ-027 In IDLE, mgmt_mosi SHALL be 0.

Reset
REQ-028 While rst_n=0, SHALL immediately force: mgmt_cs_n=1, mgmt_clk=0, mgmt_mosi=0, rsp_valid=0, rsp_rdata=0x00, busy=0, FSM=IDLE, and synchronizer and counters cleared.
REQ-029 SHALL assert req_ready on the first cycle after rst_n deasserts.
REQ-030 Reset mid-transaction SHALL abort it with no rsp_valid; the resulting mgmt_cs_n rise SHALL reset the slave's frame state.

Verification
REQ-031 Reset: rst_n=0 -> mgmt_cs_n=1, mgmt_clk=0, mgmt_mosi=0, rsp_valid=0; after release, req_ready=1.
REQ-032 Write addr 0x0C data 0xA5 (CLK_DIV=4): bits on 24 rising edges = 0x02,0x0C,0xA5 -> rsp_valid at cycle 197, rsp_rdata=0x00; slave control register = 0xA5.
REQ-033 Read addr 0x05 after writing 0x3C there -> byte 3 on MOSI = 0x00, rsp_rdata=0x3C.
REQ-034 Read addr 0x20 -> rsp_rdata=0xFF; read addr 0x0D returns slave status.
REQ-035 req_valid held high for two requests -> second accept is 5 cycles after the first rsp_valid, mgmt_cs_n high for at least 4 cycles, and req_ready=0 throughout the first transaction.
REQ-036 rst_n pulse during bit 10 -> mgmt_cs_n=1 and mgmt_clk=0 at once, no rsp_valid; a following write to 0x00 of 0x12 completes and is read back as 0x12.
